// File: rtl/fir_pkg.sv
// Shared constants for the moving-average filter family.
package fir_pkg;

  // Divide rounding modes.
  localparam int unsigned RND_TRUNC   = 0;
  localparam int unsigned RND_HALF_UP = 1;

  // Legal range of log2 window depth.
  localparam int unsigned LGN_MIN = 1;
  localparam int unsigned LGN_MAX = 6;

  // Half of the divisor, added before the shift when rounding half-up.
  function automatic int unsigned round_bias(input int unsigned rnd, input int unsigned lgn);
    return (rnd == RND_HALF_UP) ? (32'd1 << (lgn - 1)) : 32'd0;
  endfunction

endpackage

// File: rtl/dff.sv
// Generic register cell: async active-high reset, sync clear, load enable.
module dff #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear wins over load so a flush discards a coincident write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mavg_ring.sv
// Circular sample buffer of 2**lgN entries built from dff cells.
// rdata is the entry at wr_ptr, i.e. the sample about to be evicted.
module mavg_ring
  import fir_pkg::*;
#(
  parameter int unsigned bW  = 8,
  parameter int unsigned lgN = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           we,
  input  logic [bW-1:0]  wdata,
  input  logic           clear,
  output logic [bW-1:0]  rdata,
  output logic [lgN-1:0] wr_ptr
);

  localparam int unsigned N = 1 << lgN;

  logic [bW-1:0]  mem [N];
  logic [N-1:0]   cell_en;
  logic [lgN-1:0] ptr_next;

  // One-hot write enable for the slot under the write pointer.
  always_comb begin
    cell_en = '0;
    for (int i = 0; i < N; i++) begin
      cell_en[i] = we && (wr_ptr == lgN'(i));
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_cell
    dff #(.W(bW)) u_cell (
      .clk (clk),
      .rst (rst),
      .en  (cell_en[g]),
      .clr (clear),
      .d   (wdata),
      .q   (mem[g])
    );
  end

  // Pointer is exactly lgN bits, so the increment wraps N-1 -> 0.
  assign ptr_next = wr_ptr + lgN'(1);

  dff #(.W(lgN)) u_ptr (
    .clk (clk),
    .rst (rst),
    .en  (we),
    .clr (clear),
    .d   (ptr_next),
    .q   (wr_ptr)
  );

  assign rdata = mem[wr_ptr];

endmodule

// File: rtl/mavg_filter.sv
// Moving-average filter over the last 2**lgN accepted samples.
// Running sum is bW+lgN bits, which holds N full-scale samples exactly.
module mavg_filter
  import fir_pkg::*;
#(
  parameter int unsigned bW  = 8,
  parameter int unsigned lgN = 3,
  parameter int unsigned rnd = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          x_valid,
  input  logic [bW-1:0] x,
  input  logic          clear,
  output logic [bW-1:0] y,
  output logic          y_valid,
  output logic          win_full
);

  localparam int unsigned N    = 1 << lgN;
  localparam int unsigned SW   = bW + lgN;
  localparam int unsigned BIAS = round_bias(rnd, lgN);
  localparam logic [lgN:0] FULL = (lgN + 1)'(N);

  logic           accept;
  logic [bW-1:0]  oldest;
  logic [lgN-1:0] wr_ptr;
  logic           unused_ptr;

  logic [SW-1:0]  sum_q, sum_d;
  logic [SW:0]    biased;
  logic [bW:0]    quot;
  logic [bW-1:0]  y_q, y_d;
  logic           y_valid_q;
  logic [lgN:0]   fill_q, fill_d;
  logic           win_full_q;

  // Clear discards any sample presented on the same edge.
  assign accept = x_valid && !clear;

  mavg_ring #(.bW(bW), .lgN(lgN)) u_ring (
    .clk    (clk),
    .rst    (rst),
    .we     (accept),
    .wdata  (x),
    .clear  (clear),
    .rdata  (oldest),
    .wr_ptr (wr_ptr)
  );

  assign unused_ptr = ^wr_ptr;

  // Next sum, rounded quotient and saturating fill count.
  always_comb begin
    sum_d  = sum_q + SW'(x) - SW'(oldest);
    biased = {1'b0, sum_d} + (SW + 1)'(BIAS);
    quot   = biased[SW:lgN];
    y_d    = quot[bW] ? {bW{1'b1}} : quot[bW-1:0];
    fill_d = (fill_q == FULL) ? fill_q : fill_q + (lgN + 1)'(1);
  end

  // Output and accumulator registers; everything holds without an accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q      <= '0;
      y_q        <= '0;
      y_valid_q  <= 1'b0;
      fill_q     <= '0;
      win_full_q <= 1'b0;
    end else if (clear) begin
      sum_q      <= '0;
      y_q        <= '0;
      y_valid_q  <= 1'b0;
      fill_q     <= '0;
      win_full_q <= 1'b0;
    end else begin
      y_valid_q <= accept;
      if (accept) begin
        sum_q      <= sum_d;
        y_q        <= y_d;
        fill_q     <= fill_d;
        win_full_q <= (fill_d == FULL);
      end
    end
  end

  assign y        = y_q;
  assign y_valid  = y_valid_q;
  assign win_full = win_full_q;

endmodule

// File: tb/tb_mavg_filter.sv
// Self-checking bench for mavg_filter (bW=8, lgN=2) with truncating and
// half-up rounding instances driven from the same stimulus.
module tb_mavg_filter;

  localparam int unsigned BW  = 8;
  localparam int unsigned LGN = 2;
  localparam int unsigned N   = 4;

  logic          clk;
  logic          rst;
  logic          x_valid;
  logic [BW-1:0] x;
  logic          clear;
  logic [BW-1:0] y0, y1;
  logic          yv0, yv1, wf0, wf1;

  int checks;
  int errors;

  // Reference: window as a queue of the last N accepted samples.
  int unsigned win[$];
  int unsigned fill;
  int unsigned exp_y0, exp_y1;
  logic        exp_yv, exp_wf;

  mavg_filter #(.bW(BW), .lgN(LGN), .rnd(0)) dut0 (
    .clk      (clk),
    .rst      (rst),
    .x_valid  (x_valid),
    .x        (x),
    .clear    (clear),
    .y        (y0),
    .y_valid  (yv0),
    .win_full (wf0)
  );

  mavg_filter #(.bW(BW), .lgN(LGN), .rnd(1)) dut1 (
    .clk      (clk),
    .rst      (rst),
    .x_valid  (x_valid),
    .x        (x),
    .clear    (clear),
    .y        (y1),
    .y_valid  (yv1),
    .win_full (wf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    win.delete();
    fill   = 0;
    exp_y0 = 0;
    exp_y1 = 0;
    exp_yv = 1'b0;
    exp_wf = 1'b0;
  endfunction

  function automatic void model_step(input logic v, input int unsigned xv, input logic clr);
    int unsigned s;
    if (clr) begin
      model_reset();
    end else if (v) begin
      win.push_back(xv);
      if (win.size() > N) void'(win.pop_front());
      if (fill < N) fill++;
      s = 0;
      foreach (win[i]) s += win[i];
      exp_y0 = s / N;
      exp_y1 = (s + N / 2) / N;
      if (exp_y1 > 255) exp_y1 = 255;
      exp_yv = 1'b1;
      exp_wf = (fill == N);
    end else begin
      exp_yv = 1'b0;
    end
  endfunction

  // Drive one cycle of inputs, then update the model after the edge.
  task automatic step(input logic v, input int unsigned xv, input logic clr);
    @(negedge clk);
    x_valid = v;
    x       = BW'(xv);
    clear   = clr;
    @(posedge clk);
    #1;
    model_step(v, xv, clr);
    @(negedge clk);
    x_valid = 1'b0;
    clear   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    x_valid = 1'b0;
    x = '0;
    clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({y0, yv0, wf0} !== '0) begin
      errors++;
      $display("FAIL reset_rnd0: got y=%0d yv=%b wf=%b want 0 0 0", y0, yv0, wf0);
    end
    checks++;
    if ({y1, yv1, wf1} !== '0) begin
      errors++;
      $display("FAIL reset_rnd1: got y=%0d yv=%b wf=%b want 0 0 0", y1, yv1, wf1);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_warmup_evict();
    int unsigned want_warm[4]  = '{2, 4, 6, 8};
    int unsigned want_evict[4] = '{6, 4, 2, 0};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8, 1'b0);
      checks++;
      if (y0 !== BW'(want_warm[i]) || yv0 !== 1'b1 || wf0 !== (i == 3)) begin
        errors++;
        $display("FAIL warmup[%0d]: got y=%0d yv=%b wf=%b want y=%0d yv=1 wf=%b",
                 i, y0, yv0, wf0, want_warm[i], (i == 3));
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 0, 1'b0);
      checks++;
      if (y0 !== BW'(want_evict[i]) || wf0 !== 1'b1) begin
        errors++;
        $display("FAIL evict[%0d]: got y=%0d wf=%b want y=%0d wf=1", i, y0, wf0, want_evict[i]);
      end
    end
  endtask

  task automatic test_width();
    int unsigned want0[4] = '{63, 127, 191, 255};
    int unsigned want1[4] = '{64, 128, 191, 255};
    step(1'b0, 0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 255, 1'b0);
      checks++;
      if (y0 !== BW'(want0[i]) || y1 !== BW'(want1[i])) begin
        errors++;
        $display("FAIL width[%0d]: got y0=%0d y1=%0d want %0d %0d",
                 i, y0, y1, want0[i], want1[i]);
      end
    end
  endtask

  task automatic test_rounding();
    int unsigned want1[3] = '{0, 1, 1};
    step(1'b0, 0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1, 1'b0);
      checks++;
      if (y0 !== 8'd0 || y1 !== BW'(want1[i])) begin
        errors++;
        $display("FAIL rounding[%0d]: got y0=%0d y1=%0d want 0 %0d", i, y0, y1, want1[i]);
      end
    end
  endtask

  task automatic test_gaps_clear();
    logic        vseq[3]  = '{1'b1, 1'b0, 1'b1};
    int unsigned wanty[3] = '{1, 1, 2};
    step(1'b0, 0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(vseq[i], 4, 1'b0);
      checks++;
      if (y0 !== BW'(wanty[i]) || yv0 !== vseq[i]) begin
        errors++;
        $display("FAIL gap[%0d]: got y=%0d yv=%b want y=%0d yv=%b",
                 i, y0, yv0, wanty[i], vseq[i]);
      end
    end
    step(1'b1, 4, 1'b1);
    checks++;
    if (y0 !== 8'd0 || yv0 !== 1'b0 || wf0 !== 1'b0) begin
      errors++;
      $display("FAIL clear_priority: got y=%0d yv=%b wf=%b want 0 0 0", y0, yv0, wf0);
    end
    step(1'b1, 4, 1'b0);
    checks++;
    if (y0 !== 8'd1 || yv0 !== 1'b1) begin
      errors++;
      $display("FAIL after_clear: got y=%0d yv=%b want 1 1", y0, yv0);
    end
  endtask

  task automatic test_async_reset();
    step(1'b0, 0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 12, 1'b0);
    checks++;
    if (y0 !== 8'd9) begin
      errors++;
      $display("FAIL pre_reset: got y=%0d want 9", y0);
    end
    // Assert reset between edges; outputs must clear without a clock.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({y0, yv0, wf0, y1, yv1, wf1} !== '0) begin
      errors++;
      $display("FAIL async_reset: got y0=%0d yv0=%b wf0=%b y1=%0d want all 0", y0, yv0, wf0, y1);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1'b1, 12, 1'b0);
    checks++;
    if (y0 !== 8'd3 || y1 !== 8'd3 || yv0 !== 1'b1) begin
      errors++;
      $display("FAIL post_reset: got y0=%0d y1=%0d yv=%b want 3 3 1", y0, y1, yv0);
    end
  endtask

  task automatic test_random();
    logic        v, c;
    int unsigned xv;
    for (int i = 0; i < 300; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      c  = ($urandom_range(0, 29) == 0);
      xv = $urandom_range(0, 255);
      step(v, xv, c);
      checks++;
      if (y0 !== BW'(exp_y0) || y1 !== BW'(exp_y1) || yv0 !== exp_yv || yv1 !== exp_yv ||
          wf0 !== exp_wf || wf1 !== exp_wf) begin
        errors++;
        $display("FAIL random[%0d]: got y0=%0d y1=%0d yv=%b%b wf=%b%b want %0d %0d yv=%b wf=%b",
                 i, y0, y1, yv0, yv1, wf0, wf1, exp_y0, exp_y1, exp_yv, exp_wf);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_reset();
    test_reset();
    test_warmup_evict();
    test_width();
    test_rounding();
    test_gaps_clear();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
